// File: rtl/cpu6502_bus_responder_pkg.sv
// Shared definitions for the 6502 bus responder: FSM state codes,
// the open-bus read value and the external-window decode helper.
package cpu6502_bus_responder_pkg;

  // Responder FSM state codes (also exported on the debug port)
  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_REQ  = 2'd1,
    RSP_WAIT = 2'd2,
    RSP_DONE = 2'd3
  } rsp_state_e;

  // Value returned for external writes and for timed-out accesses
  localparam logic [7:0] DI_OPEN_BUS = 8'hFF;

  // Width of the shared wait/timeout counter
  localparam int TIMER_W = 8;

  // True when addr falls in the external window (only masked bits compared)
  function automatic logic win_hit(input logic [15:0] addr,
                                   input logic [15:0] base,
                                   input logic [15:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/cpu6502_wait_timer.sv
// Load/count/expire down-counter. Loaded with N, it raises expire_o in the
// N-th cycle that count_i is held high (N=0 never expires). Used by the
// responder for both the post-ack MIN_WAIT hold and the REQ timeout.
module cpu6502_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         count_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins over counting, counting saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (count_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = count_i && (cnt_q == W'(1));

endmodule

// File: rtl/cpu6502_bus_responder.sv
// Target side of the 6502 core's memory bus. Internal accesses complete with
// zero wait states (DI follows int_rdata one cycle after AB). Accesses that
// hit the external window are latched and forwarded on ext_req/ext_ack while
// RDY is held low; the captured data is returned on DI in the DONE cycle.
//
// External handshake: ext_req rises the cycle after the window hit and stays
// high, with ext_addr/ext_we/ext_wdata frozen, until a cycle in which
// ext_ack=1 is sampled; ext_rdata is taken in that same cycle. ext_ack in any
// other state is ignored.
//
// Build options:
//   CPU6502_BUS_TIMEOUT_EN : abort REQ after TIMEOUT cycles, return 8'hFF and
//                            pulse bus_err. Without it REQ waits forever and
//                            bus_err is constant 0.
//   DO_SIM                 : adds a readable state_name string for waveforms.
module cpu6502_bus_responder
  import cpu6502_bus_responder_pkg::*;
#(
  parameter logic [15:0] EXT_BASE = 16'hD000,
  parameter logic [15:0] EXT_MASK = 16'hF000,
  parameter int          MIN_WAIT = 0,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] AB,
  input  logic        WE,
  input  logic [7:0]  DO,
  output logic [7:0]  DI,
  output logic        RDY,
  input  logic [7:0]  int_rdata,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic        ext_ack,
  input  logic [7:0]  ext_rdata,
  output logic        bus_err,
  output rsp_state_e  dbg_state_o
);

  rsp_state_e state_q, state_d;

  logic        rdy_q, rdy_d;
  logic        ext_req_q, ext_req_d;
  logic        ext_we_q, ext_we_d;
  logic [15:0] ext_addr_q, ext_addr_d;
  logic [7:0]  ext_wdata_q, ext_wdata_d;
  logic        bus_err_q, bus_err_d;
  logic [7:0]  di_q, di_d;
  logic        di_sel_q, di_sel_d;

  logic        hit;
  logic        decode;
  logic        start_ext;
  logic        ack_seen;
  logic        timeout_fire;
  logic        tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic        tmr_count;
  logic        tmr_expire;

  // Address is only decoded when the CPU is free to present a new access
  assign hit       = win_hit(AB, EXT_BASE, EXT_MASK);
  assign decode    = (state_q == RSP_IDLE) || (state_q == RSP_DONE);
  assign start_ext = decode && hit;
  assign ack_seen  = (state_q == RSP_REQ) && ext_ack;

`ifdef CPU6502_BUS_TIMEOUT_EN
  // Timer runs during REQ (timeout) and WAIT (post-ack hold)
  assign tmr_count    = (state_q == RSP_REQ) || (state_q == RSP_WAIT);
  // A real ack in the expiry cycle takes priority over the timeout
  assign timeout_fire = (state_q == RSP_REQ) && !ext_ack && tmr_expire;
`else
  assign tmr_count    = (state_q == RSP_WAIT);
  assign timeout_fire = 1'b0;
`endif

  // Timeout length is loaded on entry to REQ, hold length on the ack
  assign tmr_load = start_ext || ack_seen;
  assign tmr_val  = ack_seen ? TIMER_W'(MIN_WAIT) : TIMER_W'(TIMEOUT);

  cpu6502_wait_timer #(
    .W (TIMER_W)
  ) u_wait_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .count_i    (tmr_count),
    .expire_o   (tmr_expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RSP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE decodes like IDLE so back-to-back hits skip IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      RSP_IDLE, RSP_DONE: begin
        state_d = hit ? RSP_REQ : RSP_IDLE;
      end
      RSP_REQ: begin
        if (ext_ack) begin
          state_d = (MIN_WAIT == 0) ? RSP_DONE : RSP_WAIT;
        end else if (timeout_fire) begin
          state_d = RSP_DONE;
        end
      end
      RSP_WAIT: begin
        if (tmr_expire) begin
          state_d = RSP_DONE;
        end
      end
      default: state_d = RSP_IDLE;
    endcase
  end

  // Output logic: next values of the registered bus outputs
  always_comb begin
    rdy_d       = (state_d == RSP_IDLE) || (state_d == RSP_DONE);
    ext_req_d   = (state_d == RSP_REQ);
    bus_err_d   = timeout_fire;
    di_sel_d    = (state_d == RSP_DONE);
    di_d        = di_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    if (start_ext) begin
      ext_we_d    = WE;
      ext_addr_d  = AB;
      ext_wdata_d = DO;
    end
    if (ack_seen) begin
      di_d = ext_we_q ? DI_OPEN_BUS : ext_rdata;
    end else if (timeout_fire) begin
      di_d = DI_OPEN_BUS;
    end
  end

  // Registered outputs; RDY comes straight from a flop so AB never reaches it
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdy_q       <= 1'b1;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      bus_err_q   <= 1'b0;
      di_q        <= '0;
      di_sel_q    <= 1'b0;
    end else begin
      rdy_q       <= rdy_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      bus_err_q   <= bus_err_d;
      di_q        <= di_d;
      di_sel_q    <= di_sel_d;
    end
  end

  assign RDY         = rdy_q;
  assign ext_req     = ext_req_q;
  assign ext_we      = ext_we_q;
  assign ext_addr    = ext_addr_q;
  assign ext_wdata   = ext_wdata_q;
  assign bus_err     = bus_err_q;
  assign DI          = di_sel_q ? di_q : int_rdata;
  assign dbg_state_o = state_q;

`ifdef DO_SIM
  string state_name;
  // Human-readable state for waveform viewers
  always_comb begin
    state_name = "IDLE";
    case (state_q)
      RSP_IDLE: state_name = "IDLE";
      RSP_REQ:  state_name = "REQ";
      RSP_WAIT: state_name = "WAIT";
      RSP_DONE: state_name = "DONE";
      default:  state_name = "IDLE";
    endcase
  end
`endif

endmodule

// File: tb/tb_cpu6502_bus_responder.sv
// Bench for cpu6502_bus_responder: directed vector table, hand-written
// reset/ack/timeout sequences and randomized accesses checked against a
// simple read-result/stall model.
module tb_cpu6502_bus_responder;
  import cpu6502_bus_responder_pkg::*;

  localparam logic [15:0] EXT_BASE = 16'hD000;
  localparam logic [15:0] EXT_MASK = 16'hF000;
  localparam int MIN_WAIT = 0;
  localparam int TIMEOUT  = 8;
  localparam int LIMIT    = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] AB;
  logic        WE;
  logic [7:0]  DO;
  logic [7:0]  DI;
  logic        RDY;
  logic [7:0]  int_rdata;
  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_ack;
  logic [7:0]  ext_rdata;
  logic        bus_err;
  rsp_state_e  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int         exp_stall_q[$];

  cpu6502_bus_responder #(
    .EXT_BASE (EXT_BASE),
    .EXT_MASK (EXT_MASK),
    .MIN_WAIT (MIN_WAIT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .AB          (AB),
    .WE          (WE),
    .DO          (DO),
    .DI          (DI),
    .RDY         (RDY),
    .int_rdata   (int_rdata),
    .ext_req     (ext_req),
    .ext_we      (ext_we),
    .ext_addr    (ext_addr),
    .ext_wdata   (ext_wdata),
    .ext_ack     (ext_ack),
    .ext_rdata   (ext_rdata),
    .bus_err     (bus_err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / internal memory ----------------
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return 8'h58 ^ a[7:0] ^ a[15:8];
  endfunction

  // Internal memory: registered read, one cycle after AB
  always @(posedge clk) int_rdata <= mem_fn(AB);

  // ---------------- reference model ----------------
  function automatic bit model_hit(input logic [15:0] a);
    return (a >= 16'hD000) && (a <= 16'hDFFF);
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Presents one CPU access at posedge+1 and follows it until RDY=1.
  // ack_dly = number of REQ cycles before the ack cycle (-1: never ack).
  task automatic cpu_access(input logic [15:0] ab, input logic we, input logic [7:0] d,
                            input int ack_dly, input logic [7:0] xr,
                            output logic [7:0] di_obs, output int stall,
                            output int req_cycles, output logic err_obs);
    int  guard;
    bit  acked;
    guard = 0;
    acked = 0;
    stall = 0;
    req_cycles = 0;
    AB = ab;
    WE = we;
    DO = d;
    @(posedge clk); #1;
    ext_ack   = 1'b0;
    ext_rdata = 8'($urandom);
    while (!RDY && guard < LIMIT) begin
      stall++;
      if (ext_req) begin
        req_cycles++;
        check("ext_addr", ext_addr, ab);
        check("ext_we", ext_we, we);
        check("ext_wdata", ext_wdata, d);
        if (!acked && ack_dly >= 0 && req_cycles == ack_dly + 1) begin
          ext_ack   = 1'b1;
          ext_rdata = xr;
          acked     = 1;
        end
      end
      @(posedge clk); #1;
      ext_ack   = 1'b0;
      ext_rdata = 8'($urandom);
      guard++;
    end
    if (guard >= LIMIT) check("rdy_wait_bound", RDY, 1);
    check("ext_req_low_at_ready", ext_req, 0);
    check("state_at_ready", dbg_state, model_hit(ab) ? RSP_DONE : RSP_IDLE);
    di_obs  = DI;
    err_obs = bus_err;
  endtask

  // Random access scored through the expected queues
  task automatic run_and_score(input logic [15:0] ab, input logic we, input logic [7:0] d,
                               input int ack_dly, input logic [7:0] xr);
    logic [7:0] di_obs;
    int         stall, reqc;
    logic       err;
    logic [7:0] e_di;
    int         e_stall;
    if (model_hit(ab)) begin
      exp_q.push_back(we ? 8'hFF : xr);
      exp_stall_q.push_back(1 + ack_dly + MIN_WAIT);
    end else begin
      exp_q.push_back(mem_fn(ab));
      exp_stall_q.push_back(0);
    end
    cpu_access(ab, we, d, ack_dly, xr, di_obs, stall, reqc, err);
    e_di    = exp_q.pop_front();
    e_stall = exp_stall_q.pop_front();
    check("rand_di", di_obs, e_di);
    check("rand_stall", stall, e_stall);
    check("rand_bus_err", err, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [15:0] ab;
    logic        we;
    logic [7:0]  dout;
    int          ack_dly;
    logic [7:0]  xr;
    logic [7:0]  exp_di;
    int          exp_stall;
    int          exp_req;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0] di_obs;
    int         stall, reqc;
    logic       err;

    vecs[0] = '{16'h0200, 1'b0, 8'h00, 0,  8'h00, 8'h5A, 0, 0};
    vecs[1] = '{16'hD012, 1'b0, 8'h00, 3,  8'hC3, 8'hC3, 4, 4};
    vecs[2] = '{16'hD400, 1'b1, 8'h77, 2,  8'h00, 8'hFF, 3, 3};
    vecs[3] = '{16'hD000, 1'b0, 8'h00, 0,  8'h11, 8'h11, 1, 1};
    vecs[4] = '{16'hD001, 1'b0, 8'h00, 1,  8'h22, 8'h22, 2, 2};
    vecs[5] = '{16'h0300, 1'b1, 8'h99, 0,  8'h00, 8'h5B, 0, 0};
    vecs[6] = '{16'hCFFF, 1'b0, 8'h00, 0,  8'h00, 8'h68, 0, 0};
    vecs[7] = '{16'hDFFF, 1'b0, 8'h00, 0,  8'hA5, 8'hA5, 1, 1};
    vecs[8] = '{16'hE000, 1'b0, 8'h00, 0,  8'h00, 8'hB8, 0, 0};
    vecs[9] = '{16'hD800, 1'b1, 8'h3C, 4,  8'h00, 8'hFF, 5, 5};

    // ---- reset (window address held on the bus must be ignored) ----
    reset = 1'b0; AB = 16'hD123; WE = 1'b1; DO = 8'h44;
    ext_ack = 1'b0; ext_rdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", RDY, 1);
    check("rst_ext_req", ext_req, 0);
    check("rst_ext_we", ext_we, 0);
    check("rst_ext_addr", ext_addr, 0);
    check("rst_ext_wdata", ext_wdata, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_di", DI, int_rdata);
    check("rst_state", dbg_state, RSP_IDLE);
    AB = 16'h0000; WE = 1'b0; DO = 8'h00;
    reset = 1'b1;
    @(posedge clk); #1;

    // ---- directed table (consecutive entries run back-to-back) ----
    for (int i = 0; i < 10; i++) begin
      cpu_access(vecs[i].ab, vecs[i].we, vecs[i].dout, vecs[i].ack_dly, vecs[i].xr,
                 di_obs, stall, reqc, err);
      check($sformatf("vec%0d_di", i), di_obs, vecs[i].exp_di);
      check($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
      check($sformatf("vec%0d_req_cycles", i), reqc, vecs[i].exp_req);
      check($sformatf("vec%0d_bus_err", i), err, 0);
    end

    // ---- ext_ack while idle is ignored ----
    AB = 16'h0100; WE = 1'b0;
    @(posedge clk); #1;
    ext_ack = 1'b1; ext_rdata = 8'hEE;
    @(posedge clk); #1;
    ext_ack = 1'b0;
    check("stray_ack_rdy", RDY, 1);
    check("stray_ack_req", ext_req, 0);
    check("stray_ack_state", dbg_state, RSP_IDLE);
    check("stray_ack_di", DI, mem_fn(16'h0100));

    // ---- reset asserted in the middle of REQ ----
    AB = 16'hD100; WE = 1'b0;
    @(posedge clk); #1;
    check("midreq_req_up", ext_req, 1);
    @(posedge clk); #1;
    reset = 1'b0; AB = 16'h0200;
    @(posedge clk); #1;
    check("midreq_rst_req", ext_req, 0);
    check("midreq_rst_rdy", RDY, 1);
    check("midreq_rst_state", dbg_state, RSP_IDLE);
    check("midreq_rst_addr", ext_addr, 0);
    reset = 1'b1;
    run_and_score(16'h0200, 1'b0, 8'h00, 0, 8'h00);
    run_and_score(16'hD055, 1'b0, 8'h00, 2, 8'h6E);

`ifdef CPU6502_BUS_TIMEOUT_EN
    // ---- timeout: no ack, forced completion, late ack ignored ----
    cpu_access(16'hD0AA, 1'b0, 8'h00, -1, 8'h00, di_obs, stall, reqc, err);
    check("to_di", di_obs, 8'hFF);
    check("to_stall", stall, TIMEOUT);
    check("to_req_cycles", reqc, TIMEOUT);
    check("to_bus_err", err, 1);
    AB = 16'h0200; WE = 1'b0;
    ext_ack = 1'b1; ext_rdata = 8'h12;
    @(posedge clk); #1;
    ext_ack = 1'b0;
    check("to_err_pulse_end", bus_err, 0);
    check("to_late_ack_req", ext_req, 0);
    check("to_late_ack_rdy", RDY, 1);
    run_and_score(16'hD0AB, 1'b0, 8'h00, 1, 8'h9C);
`endif

    // ---- randomized accesses ----
    for (int n = 0; n < 40; n++) begin
      logic [15:0] ab;
      ab = 16'($urandom);
      if ($urandom_range(0, 1) == 1) ab = {4'hD, ab[11:0]};
      run_and_score(ab, 1'($urandom_range(0, 1)), 8'($urandom),
                    int'($urandom_range(0, 5)), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
